// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the 16:1 bit-select mux scan sequencer.
// Defines the datapath widths, the FSM state encoding and the effective-count helper.
// Imported by the interface, the top level and the bit-select sub-module.
package mux_scan_sequencer_pkg;

    localparam int WIDTH = 16;  // data word width, equal to 2**SEL_W
    localparam int SEL_W = 4;   // mux select width
    localparam int CNT_W = 5;   // bit-count width, wide enough to hold WIDTH

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // A count of zero, or one larger than the word, means "the whole word".
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] bc);
        if ((bc == '0) || (bc > CNT_W'(WIDTH))) begin
            return CNT_W'(WIDTH);
        end
        return bc;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Word-in / bit-serial-out bundle of the mux scan sequencer.
// Ports: word offer (in_valid/in_ready/in_data plus start_sel, msb_first, bit_count),
//        serial stream (ser_out/ser_valid/ser_ready/ser_last) and status (sel, busy, done).
interface mux_scan_sequencer_if
    import mux_scan_sequencer_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_SEL_W = SEL_W,
    parameter int P_CNT_W = CNT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [P_WIDTH-1:0] in_data;
    logic [P_SEL_W-1:0] start_sel;
    logic               msb_first;
    logic [P_CNT_W-1:0] bit_count;
    logic               ser_out;
    logic               ser_valid;
    logic               ser_ready;
    logic               ser_last;
    logic [P_SEL_W-1:0] sel;
    logic               busy;
    logic               done;

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, start_sel, msb_first, bit_count, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, sel, busy, done
    );

    // Producer / consumer side.
    modport master (
        output in_valid, in_data, start_sel, msb_first, bit_count, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, sel, busy, done
    );
endinterface

// File: rtl/mux_scan_sequencer_word_bit_mux.sv
// WIDTH:1 combinational bit select: bit_o = data_i[sel_i].
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module word_bit_mux
    import mux_scan_sequencer_pkg::*;
#(
    parameter int P_WIDTH = WIDTH,
    parameter int P_SEL_W = SEL_W
) (
    input  logic [P_WIDTH-1:0] data_i,
    input  logic [P_SEL_W-1:0] sel_i,
    output logic               bit_o
);
    assign bit_o = data_i[sel_i];
endmodule

// File: rtl/mux_scan_sequencer.sv
// Latches a word and walks a 16:1 mux select up or down (mod 16) to emit a serial bit stream.
// Latency: first bit valid one cycle after the word handshake; N bits + DONE + IDLE cycles per word.
// Backpressure: ser_ready low freezes sel, remaining count, ser_out and ser_last; in_ready only in IDLE.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.slave   bus
);
    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   sel_q;
    logic               dir_q;       // 1: walk downwards
    logic [CNT_W-1:0]   rem_q;       // bits still to emit, including the one on the wire
    logic               ser_valid_q;
    logic               ser_last_q;
    logic               done_q;
    logic               busy_q;
    logic               in_ready_q;

    logic [SEL_W-1:0]   sel_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               ser_bit;

    // Natural SEL_W-bit wrap gives 15->0 going up and 0->15 going down.
    assign sel_d = dir_q ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
    assign cnt_d = eff_count(bus.bit_count);

    // in_ready resets low and rises on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            rem_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        data_q      <= bus.in_data;
                        sel_q       <= bus.start_sel;
                        dir_q       <= bus.msb_first;
                        rem_q       <= cnt_d;
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= (cnt_d == CNT_W'(1));
                        busy_q      <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.ser_ready) begin
                        if (rem_q == CNT_W'(1)) begin
                            ser_valid_q <= 1'b0;
                            ser_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            sel_q      <= sel_d;
                            rem_q      <= rem_q - CNT_W'(1);
                            ser_last_q <= (rem_q == CNT_W'(2));
                        end
                    end
                end
                ST_DONE: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    word_bit_mux #(
        .P_WIDTH (WIDTH),
        .P_SEL_W (SEL_W)
    ) u_bit_mux (
        .data_i (data_q),
        .sel_i  (sel_q),
        .bit_o  (ser_bit)
    );

    assign bus.ser_out   = ser_bit;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_q;

endmodule
